// File: rtl/paddle_pkg.sv
// Shared constants, y-coordinate type, FSM state encoding and clamp helpers
// for the paddle position controller.
package paddle_pkg;

  localparam int Y_W = 10;
  typedef logic [Y_W-1:0] y_t;

  localparam y_t FIELD_TOP     = 10'd8;
  localparam y_t FIELD_BOTTOM  = 10'd472;
  localparam y_t PADDLE_HEIGHT = 10'd48;
  localparam y_t Y_MAX         = FIELD_BOTTOM - PADDLE_HEIGHT;
  localparam y_t Y_INIT        = 10'd216;
  localparam y_t STEP          = 10'd4;
  localparam y_t STEP_MAX      = 10'd12;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2
  } state_e;

  // Compare before subtracting so the 10-bit result can never wrap below the field.
  function automatic y_t clamp_up(input y_t y, input y_t step);
    if (y < FIELD_TOP + step) return FIELD_TOP;
    return y - step;
  endfunction

  function automatic y_t clamp_down(input y_t y, input y_t step);
    if (y + step > Y_MAX) return Y_MAX;
    return y + step;
  endfunction

  function automatic y_t step_inc(input y_t step);
    if (step >= STEP_MAX) return STEP_MAX;
    return step + 10'd1;
  endfunction

endpackage

// File: rtl/paddle_pos_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a stability counter; a new
// button level is accepted only after DEBOUNCE_CYCLES consecutive differing clocks.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 125000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic db_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first on every path, so no latch is inferred.
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/paddle_pos_ctrl.sv
// Paddle vertical position from debounced up/down buttons, updated once per frame.
// Optional build macro PADDLE_ACCEL_EN grows the step while a direction is held.
module paddle_pos_ctrl
  import paddle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 125000,
  parameter logic [10:0] FRAME_LINE      = 11'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic [31:0] y_pos,
  output logic        moving,
  output logic        at_limit,
  output logic        frame_tick
);

  logic   up_db, down_db;
  logic   press_up, press_down;
  logic   tick_q, tick_d;
  state_e state_q, state_d;
  y_t     y_q, y_d;
  y_t     step_cur;
`ifdef PADDLE_ACCEL_EN
  y_t     step_q;
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_up (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_up),
    .db_o  (up_db)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_down (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_down),
    .db_o  (down_db)
  );

  // Both buttons held together count as no request at all.
  assign press_up   = up_db & ~down_db;
  assign press_down = down_db & ~up_db;

  assign tick_d = (hcount == 11'd0) && (vcount == FRAME_LINE);

  always_comb begin
    state_d = state_q;
    if (tick_q) begin
      case (state_q)
        ST_IDLE: begin
          if (press_up)        state_d = ST_MOVE_UP;
          else if (press_down) state_d = ST_MOVE_DOWN;
        end
        ST_MOVE_UP: begin
          if (press_down)      state_d = ST_MOVE_DOWN;
          else if (!press_up)  state_d = ST_IDLE;
        end
        ST_MOVE_DOWN: begin
          if (press_up)         state_d = ST_MOVE_UP;
          else if (!press_down) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Step for this frame: base step on entry, otherwise one more than last frame.
  always_comb begin
    step_cur = STEP;
`ifdef PADDLE_ACCEL_EN
    if ((state_d != ST_IDLE) && (state_d == state_q)) step_cur = step_inc(step_q);
`endif
  end

  // The update uses the next state, so a fresh press moves on the same tick.
  always_comb begin
    y_d = y_q;
    if (tick_q) begin
      case (state_d)
        ST_MOVE_UP:   y_d = clamp_up(y_q, step_cur);
        ST_MOVE_DOWN: y_d = clamp_down(y_q, step_cur);
        default:      y_d = y_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q  <= 1'b0;
      state_q <= ST_IDLE;
      y_q     <= Y_INIT;
    end else begin
      tick_q  <= tick_d;
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

`ifdef PADDLE_ACCEL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= STEP;
    end else if (tick_q) begin
      step_q <= step_cur;
    end
  end
`endif

  assign y_pos      = 32'(y_q);
  assign moving     = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN);
  assign at_limit   = (y_q == FIELD_TOP) || (y_q == Y_MAX);
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Scoreboard bench for paddle_pos_ctrl: a frame-level reference model pushes the
// expected result of every position update, a monitor pops it when the DUT ticks.
module tb_paddle_pos_ctrl;

  localparam int DC     = 4;
  localparam int H_COLS = 8;
  localparam int V_FIRST = 474;
  localparam int V_LAST  = 485;
`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [10:0] hcount = 11'd0;
  logic [10:0] vcount = 11'(V_FIRST);
  logic [31:0] y_pos;
  logic        moving, at_limit, frame_tick;

  paddle_pos_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .hcount     (hcount),
    .vcount     (vcount),
    .y_pos      (y_pos),
    .moving     (moving),
    .at_limit   (at_limit),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reduced raster: 8 columns, lines 474..485, so line 480 comes once per 96 clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (int'(hcount) == H_COLS - 1) begin
        hcount = 11'd0;
        vcount = (int'(vcount) == V_LAST) ? 11'(V_FIRST) : vcount + 11'd1;
      end else begin
        hcount = hcount + 11'd1;
      end
    end
  end

  typedef struct {
    int y;
    bit mv;
    bit lim;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: buttons accepted after DC stable clocks, one move per frame.
  int m_y = 216;
  int m_dir = 0;   // +1 up, -1 down, 0 none
  int m_run = 0;   // consecutive frames in the same direction
  bit m_tick = 1'b0;
  bit m_s1[2], m_s2[2], m_db[2];
  int m_cnt[2];

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_y = 216; m_dir = 0; m_run = 0; m_tick = 1'b0;
        for (int b = 0; b < 2; b++) begin
          m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_db[b] = 1'b0; m_cnt[b] = 0;
        end
        exp_q.delete();
      end else begin
        if (m_tick) begin
          int dir, step;
          dir = (m_db[0] && !m_db[1]) ? 1 : ((m_db[1] && !m_db[0]) ? -1 : 0);
          if (dir == 0)          m_run = 0;
          else if (dir == m_dir) m_run++;
          else                   m_run = 1;
          m_dir = dir;
          step = 4;
          if (ACCEL) step = (4 + m_run - 1 > 12) ? 12 : 4 + m_run - 1;
          if (dir == 1)       m_y = (m_y - step < 8) ? 8 : m_y - step;
          else if (dir == -1) m_y = (m_y + step > 424) ? 424 : m_y + step;
          exp_q.push_back('{y: m_y, mv: (dir != 0), lim: (m_y == 8 || m_y == 424)});
        end
        for (int b = 0; b < 2; b++) begin
          if (m_s2[b] == m_db[b]) begin
            m_cnt[b] = 0;
          end else begin
            m_cnt[b]++;
            if (m_cnt[b] == DC) begin
              m_db[b] = m_s2[b];
              m_cnt[b] = 0;
            end
          end
        end
        m_s2 = m_s1;
        m_s1[0] = btn_up;
        m_s1[1] = btn_down;
        m_tick = (hcount == 11'd0) && (int'(vcount) == 480);
      end
    end
  end

  // Monitor: frame_tick every cycle, full result one clock after each tick.
  initial begin
    bit pending = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("frame_tick", frame_tick, m_tick);
      if (pending && !reset) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL scoreboard_empty: DUT ticked, expected no update (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_y_pos", y_pos, 32'(e.y));
          check("sb_moving", moving, e.mv);
          check("sb_at_limit", at_limit, e.lim);
        end
      end
      pending = frame_tick && !reset;
    end
  end

  task automatic wait_tick();
    int budget = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (frame_tick !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL frame_wait: no frame_tick within %0d cycles", budget);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < n; i++) wait_tick();
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. one-clock reset
    @(negedge clk);
    reset = 1'b0;
    check("rst_y_pos", y_pos, 32'd216);
    check("rst_moving", moving, 1'b0);
    check("rst_at_limit", at_limit, 1'b0);
    check("rst_frame_tick", frame_tick, 1'b0);

    // 2. a 3-clock glitch is never accepted
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    wait_frames(3);
    check("glitch_y_pos", y_pos, 32'd216);
    check("glitch_moving", moving, 1'b0);

    // held 2+4 clocks: accepted exactly on the sixth edge
    btn_up = 1'b1;
    repeat (5) @(negedge clk);
    check("db_up_5clk", dut.u_dbnc_up.db_o, 1'b0);
    @(negedge clk);
    check("db_up_6clk", dut.u_dbnc_up.db_o, 1'b1);

    // 3. latency: y unchanged during the tick cycle, updated one clock later
    wait_tick();
    check("lat_y_in_tick", y_pos, 32'd216);
    @(negedge clk);
    check("lat_y_after_tick", y_pos, 32'd212);
    check("lat_moving", moving, 1'b1);
    wait_frames(4);
    check("five_frames_y", y_pos, ACCEL ? 32'd186 : 32'd196);

    // 1b. reset mid-move once y_pos has reached 300
    btn_up = 1'b0;
    btn_down = 1'b1;
    for (int i = 0; i < 40 && y_pos < 300; i++) wait_frames(1);
    check("pre_reset_moving", moving, 1'b1);
    reset = 1'b1;
    btn_down = 1'b0;
    @(negedge clk);
    check("midrst_y_pos", y_pos, 32'd216);
    check("midrst_moving", moving, 1'b0);
    check("midrst_frame_tick", frame_tick, 1'b0);
    reset = 1'b0;

    // 4. clamp at the bottom, then at the top
    btn_down = 1'b1;
    for (int i = 0; i < 80 && y_pos != 424; i++) wait_frames(1);
    check("bot_y_pos", y_pos, 32'd424);
    check("bot_at_limit", at_limit, 1'b1);
    wait_frames(3);
    check("bot_hold_y_pos", y_pos, 32'd424);
    check("bot_hold_moving", moving, 1'b1);
    btn_down = 1'b0;
    btn_up = 1'b1;
    for (int i = 0; i < 140 && y_pos != 8; i++) wait_frames(1);
    check("top_y_pos", y_pos, 32'd8);
    check("top_at_limit", at_limit, 1'b1);
    wait_frames(2);
    check("top_hold_y_pos", y_pos, 32'd8);
    check("top_hold_moving", moving, 1'b1);

    // 5. simultaneous buttons: down two frames from 8, then both held
    btn_up = 1'b0;
    btn_down = 1'b1;
    wait_frames(2);
    check("down2_y_pos", y_pos, ACCEL ? 32'd17 : 32'd16);
    btn_up = 1'b1;
    wait_frames(1);
    check("both_moving", moving, 1'b0);
    check("both_y_pos", y_pos, ACCEL ? 32'd17 : 32'd16);
    wait_frames(1);
    check("both_frozen_y", y_pos, ACCEL ? 32'd17 : 32'd16);
    btn_down = 1'b0;
    wait_frames(1);
    check("up_after_both_moving", moving, 1'b1);
    check("up_after_both_y", y_pos, ACCEL ? 32'd13 : 32'd12);

    // 6. release for one frame, press again: step restarts at 4
    btn_up = 1'b0;
    wait_frames(1);
    check("release_moving", moving, 1'b0);
    btn_up = 1'b1;
    wait_frames(1);
    check("repress_y_pos", y_pos, ACCEL ? 32'd9 : 32'd8);

    // random button segments, some shorter than the debounce window
    for (int s = 0; s < 60; s++) begin
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 250)) @(negedge clk);
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    wait_frames(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
